clk_param_meter: RTL
====================

# clk_param_meter

Synthesizable measurement stage that consumes a generated clock-like waveform and reports its phase, high time and low time in reference-clock cycles. It is the checker counterpart of the parameterised clock generator (phase / ton / toff). It sits downstream of the generator, in the reference `clk` domain, and publishes one result per waveform period, so benches and on-chip monitors can confirm that the generated waveform matches its programmed parameters.

## Interface
Parameters:
- CNT_W, 16, width of every counter and result output

Ports:
- clk  in  1  reference clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse: clear results, begin a new measurement
- stop  in  1  single-cycle pulse: abort the measurement and return to IDLE
- sig_in  in  1  measured waveform; synchronous to clk
- busy  out  1  high in every state except IDLE
- phase_out  out  CNT_W  cycles from start to the first rising edge of sig_in
- phase_valid  out  1  one-cycle pulse when phase_out updates
- ton_out  out  CNT_W  high time of the last completed period
- toff_out  out  CNT_W  low time of the last completed period
- meas_valid  out  1  one-cycle pulse when ton_out/toff_out update
- overflow  out  1  sticky flag; set when any counter saturates

## Operation
- sig_q is a register that holds sig_in. It updates every cycle, including in IDLE.
- rise = sig_in & ~sig_q. fall = ~sig_in & sig_q.
- States and transitions:
  - IDLE: on start, clear phase_cnt and overflow, then go to WAIT_RISE.
  - WAIT_RISE: phase_cnt increments on every edge. On rise: phase_out <= phase_cnt + 1, phase_valid pulses, ton_cnt <= 1, go to HIGH.
  - HIGH: ton_cnt increments while sig_in = 1. On fall: toff_cnt <= 1, go to LOW.
  - LOW: toff_cnt increments while sig_in = 0. On rise: ton_out <= ton_cnt, toff_out <= toff_cnt, meas_valid pulses, ton_cnt <= 1, go to HIGH.
- Phase definition: phase = number of clk edges after the edge that sampled start, up to and including the edge that sampled the rise.
- ton = number of edges that sampled sig_in = 1 in one high period. toff is the same for sig_in = 0.
- The first high period after the first rise is measured. meas_valid first pulses at the second rise.
- If sig_in is already high when start is sampled, WAIT_RISE keeps counting until a genuine low-to-high transition.
- Saturation: counters stop at 2^CNT_W − 1 and set overflow. A saturated value is still published at the next edge event.
- overflow clears only on start or rst.
- start while busy: restart immediately. Counters and overflow clear, state goes to WAIT_RISE. ton_out, toff_out and phase_out hold their old values until they are overwritten.
- stop: go to IDLE with no valid pulse. Result outputs hold their values.
- start and stop in the same cycle: stop wins.

## Timing
- Reset values: busy = 0, phase_valid = 0, meas_valid = 0, overflow = 0, phase_out = 0, ton_out = 0, toff_out = 0, state = IDLE, sig_q = 0.
- rst mid-operation: all of the above apply on the next edge. No valid pulse is emitted.
- All outputs are registered.
- Latency:
  - phase_valid and meas_valid are high for exactly one cycle.
  - They are visible immediately after the edge that samples the rise, i.e. 1 cycle after sig_in goes high in the synchronous domain.
  - Published data is stable in the same cycle as its valid pulse.
- busy rises the cycle after start is sampled. It falls the cycle after stop is sampled.
- Minimum measurable high or low time is 1 cycle. A 1-cycle-high, 1-cycle-low waveform gives ton = 1, toff = 1, with meas_valid every 2 cycles.

## Test plan
- start, sig_in low for 9 edges then repeating 3 high / 2 low → phase_out = 10 with phase_valid; from the second rise on, ton_out = 3, toff_out = 2, meas_valid every 5 cycles; overflow = 0.
- sig_in high when start is sampled, falls after 4 cycles, rises 6 cycles later → phase_out = 10 (4 + 6); no earlier phase_valid.
- CNT_W = 4, sig_in held low for 20 cycles after start, then pattern 2 high / 20 low → phase_out = 15, toff_out = 15, overflow = 1; overflow stays set until the next start.
- start re-pulsed in the middle of LOW → no meas_valid for the interrupted period; phase is re-measured from the new start; previous ton_out and toff_out hold until the next meas_valid.
- rst asserted in the middle of HIGH → next cycle busy = 0 and all outputs = 0; no valid pulse. stop asserted together with start → state stays IDLE, busy = 0.
- 1 high / 1 low waveform → ton_out = 1, toff_out = 1, with meas_valid asserted on every second cycle.

Source files
------------

// File: rtl/clk_param_meter.sv
// rtl/clk_param_meter.sv - measures phase, high time and low time of a clock-like waveform in clk cycles
module clk_param_meter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             sig_in,
  output logic             busy,
  output logic [CNT_W-1:0] phase_out,
  output logic             phase_valid,
  output logic [CNT_W-1:0] ton_out,
  output logic [CNT_W-1:0] toff_out,
  output logic             meas_valid,
  output logic             overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_RISE,
    S_HIGH,
    S_LOW
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  state_t           r_state;
  logic             r_sig_q;
  logic [CNT_W-1:0] r_phase_cnt;
  logic [CNT_W-1:0] r_ton_cnt;
  logic [CNT_W-1:0] r_toff_cnt;
  logic [CNT_W-1:0] r_phase_out;
  logic [CNT_W-1:0] r_ton_out;
  logic [CNT_W-1:0] r_toff_out;
  logic             r_phase_valid;
  logic             r_meas_valid;
  logic             r_overflow;
  logic             r_busy;

  logic             w_rise;
  logic             w_fall;
  logic             w_phase_sat;
  logic             w_ton_sat;
  logic             w_toff_sat;
  logic [CNT_W-1:0] w_phase_inc;
  logic [CNT_W-1:0] w_ton_inc;
  logic [CNT_W-1:0] w_toff_inc;

  // Edge detection compares the live sample against last cycle's sample.
  assign w_rise = sig_in & ~r_sig_q;
  assign w_fall = ~sig_in & r_sig_q;

  // Saturating increments: a counter at all-ones holds and reports saturation.
  assign w_phase_sat = &r_phase_cnt;
  assign w_ton_sat   = &r_ton_cnt;
  assign w_toff_sat  = &r_toff_cnt;
  assign w_phase_inc = w_phase_sat ? r_phase_cnt : r_phase_cnt + CNT_ONE;
  assign w_ton_inc   = w_ton_sat   ? r_ton_cnt   : r_ton_cnt + CNT_ONE;
  assign w_toff_inc  = w_toff_sat  ? r_toff_cnt  : r_toff_cnt + CNT_ONE;

  // Delayed copy of sig_in, kept running in every state so edges are never stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sig_q <= 1'b0;
    end else begin
      r_sig_q <= sig_in;
    end
  end

  // Measurement FSM with registered results, pulses and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_phase_cnt   <= CNT_ZERO;
      r_ton_cnt     <= CNT_ZERO;
      r_toff_cnt    <= CNT_ZERO;
      r_phase_out   <= CNT_ZERO;
      r_ton_out     <= CNT_ZERO;
      r_toff_out    <= CNT_ZERO;
      r_phase_valid <= 1'b0;
      r_meas_valid  <= 1'b0;
      r_overflow    <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_phase_valid <= 1'b0;
      r_meas_valid  <= 1'b0;
      if (stop) begin
        // Abort wins over start; results are left untouched.
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else if (start) begin
        // Start from any state restarts the phase measurement.
        r_state     <= S_WAIT_RISE;
        r_busy      <= 1'b1;
        r_phase_cnt <= CNT_ZERO;
        r_overflow  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_busy <= 1'b0;
          end
          S_WAIT_RISE: begin
            if (w_rise) begin
              // The rising edge itself counts toward the phase.
              r_phase_out   <= w_phase_inc;
              r_phase_valid <= 1'b1;
              r_ton_cnt     <= CNT_ONE;
              r_state       <= S_HIGH;
              if (w_phase_sat) begin
                r_overflow <= 1'b1;
              end
            end else begin
              r_phase_cnt <= w_phase_inc;
              if (w_phase_sat) begin
                r_overflow <= 1'b1;
              end
            end
          end
          S_HIGH: begin
            if (w_fall) begin
              r_toff_cnt <= CNT_ONE;
              r_state    <= S_LOW;
            end else if (sig_in) begin
              r_ton_cnt <= w_ton_inc;
              if (w_ton_sat) begin
                r_overflow <= 1'b1;
              end
            end
          end
          S_LOW: begin
            if (w_rise) begin
              // A full period has completed: publish it and start the next.
              r_ton_out    <= r_ton_cnt;
              r_toff_out   <= r_toff_cnt;
              r_meas_valid <= 1'b1;
              r_ton_cnt    <= CNT_ONE;
              r_state      <= S_HIGH;
            end else if (!sig_in) begin
              r_toff_cnt <= w_toff_inc;
              if (w_toff_sat) begin
                r_overflow <= 1'b1;
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy        = r_busy;
  assign phase_out   = r_phase_out;
  assign phase_valid = r_phase_valid;
  assign ton_out     = r_ton_out;
  assign toff_out    = r_toff_out;
  assign meas_valid  = r_meas_valid;
  assign overflow    = r_overflow;

endmodule
